// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the board input conditioner.
package input_cond_pkg;

   // 20 ms of stable input at a 50 MHz HCLK
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

   // Bits needed for a debounce counter that counts up to n-1 without wrapping
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounce cell. It holds a stable value and updates it only after the
// synchronised input has differed from it for DEBOUNCE_CYCLES consecutive
// cycles. A WIDTH>1 cell treats its input as a single word: the counter keeps
// running while the word differs from the stable value, even if the word
// itself moves, and the word seen on the completing cycle is captured.
module debounce_cell
   import input_cond_pkg::*;
#(
   parameter int unsigned      WIDTH           = 1,
   parameter int unsigned      DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             changed,
   output logic [WIDTH-1:0] rose
);

   localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             changed_q, changed_d;
   logic [WIDTH-1:0] rose_q, rose_d;

   // Next state: clear on agreement, commit on the last differing cycle, else count
   always_comb begin
      stable_d  = stable_q;
      cnt_d     = cnt_q;
      changed_d = 1'b0;
      rose_d    = '0;
      if (d == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d  = d;
         cnt_d     = '0;
         changed_d = 1'b1;
         rose_d    = d & ~stable_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // State and pulse registers; pulses land in the same cycle as the new value
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         stable_q  <= RESET_VAL;
         cnt_q     <= '0;
         changed_q <= 1'b0;
         rose_q    <= '0;
      end else begin
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         changed_q <= changed_d;
         rose_q    <= rose_d;
      end
   end

   assign q       = stable_q;
   assign changed = changed_q;
   assign rose    = rose_q;

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: synchronises the raw keys and switches into HCLK,
// debounces each key independently and the switch word as a whole, and
// presents clean levels plus single-cycle change pulses to the SoC.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int unsigned N_BUTTONS       = 2,
   parameter int unsigned N_SWITCHES      = 16,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [N_BUTTONS-1:0]  KEY_n,
   input  logic [N_SWITCHES-1:0] SW,
   output logic [N_BUTTONS-1:0]  Buttons,
   output logic [N_BUTTONS-1:0]  ButtonPressed,
   output logic [N_SWITCHES-1:0] Switches,
   output logic                  SwitchesChanged
);

   logic [N_BUTTONS-1:0]  key_sync;
   logic [N_BUTTONS-1:0]  btn_changed;
   logic [N_SWITCHES-1:0] sw_sync;
   logic [N_SWITCHES-1:0] sw_rose;
   logic                  unused_pulses;

   genvar gi;

   // Keys: invert at the chain input so everything downstream is active-high.
   // The flops reset to the released state, which is 0 after the inversion.
   for (gi = 0; gi < N_BUTTONS; gi++) begin : g_key
      logic [SYNC_STAGES-1:0] chain_q;

      // Plain shift chain, nothing between stages
      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            chain_q <= '0;
         end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], ~KEY_n[gi]};
         end
      end

      assign key_sync[gi] = chain_q[SYNC_STAGES-1];

      debounce_cell #(
         .WIDTH           (1),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (1'b0)
      ) u_key_db (
         .HCLK    (HCLK),
         .HRESETn (HRESETn),
         .d       (key_sync[gi]),
         .q       (Buttons[gi]),
         .changed (btn_changed[gi]),
         .rose    (ButtonPressed[gi])
      );
   end

   // Switches: one synchroniser chain per bit, reset to 0
   for (gi = 0; gi < N_SWITCHES; gi++) begin : g_sw
      logic [SYNC_STAGES-1:0] chain_q;

      // Plain shift chain, nothing between stages
      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            chain_q <= '0;
         end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], SW[gi]};
         end
      end

      assign sw_sync[gi] = chain_q[SYNC_STAGES-1];
   end

   // The whole switch word shares one debounce cell so it updates atomically
   debounce_cell #(
      .WIDTH           (N_SWITCHES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       ({N_SWITCHES{1'b0}})
   ) u_sw_db (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .d       (sw_sync),
      .q       (Switches),
      .changed (SwitchesChanged),
      .rose    (sw_rose)
   );

   // Per-key change pulses and per-bit switch rises are not needed by the SoC
   assign unused_pulses = ^{btn_changed, sw_rose};

endmodule
